// File: rtl/rangebin_sequencer.sv
// Range-bin sweep sequencer: walks the bins of one frame through the calc
// engine, counts frames per spectrum accumulation and issues the accumulation
// clear once the receiver's delayed bin count has settled.
module rangebin_sequencer #(
  parameter int N_BINS  = 32,
  parameter int ACC_NUM = 16,
  parameter int TIMEOUT = 1024,
  parameter int GUARD   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       abort,
  input  logic       calc_ack,
  output logic       calc_req,
  output logic [4:0] calc_bin,
  output logic       cal_done,
  output logic       SPEC_Acc_Done,
  output logic       busy,
  output logic [7:0] acc_count,
  output logic       overrun,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_WAIT, ST_DONE, ST_GUARD, ST_ACC
  } state_t;

  localparam logic [4:0]  LAST_BIN   = 5'(N_BINS - 1);
  localparam logic [7:0]  ACC_LIMIT  = 8'(ACC_NUM);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic [15:0] guard_cnt, guard_nxt;
  logic [4:0]  bin_nxt;
  logic [7:0]  acc_nxt, acc_inc;
  logic        req_nxt, done_nxt, spec_nxt, busy_nxt, over_nxt, tmo_nxt;

  // State, counters and every output are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      guard_cnt     <= '0;
      calc_bin      <= '0;
      acc_count     <= '0;
      calc_req      <= 1'b0;
      cal_done      <= 1'b0;
      SPEC_Acc_Done <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_nxt;
      guard_cnt     <= guard_nxt;
      calc_bin      <= bin_nxt;
      acc_count     <= acc_nxt;
      calc_req      <= req_nxt;
      cal_done      <= done_nxt;
      SPEC_Acc_Done <= spec_nxt;
      busy          <= busy_nxt;
      overrun       <= over_nxt;
      timeout_err   <= tmo_nxt;
    end
  end

  // Next-state and next-output decode; pulses are derived from the state being
  // entered so each registered pulse lines up with its state.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    guard_nxt = guard_cnt;
    bin_nxt   = calc_bin;
    acc_nxt   = acc_count;
    acc_inc   = 8'(acc_count + 8'd1);
    req_nxt   = 1'b0;
    done_nxt  = 1'b0;
    spec_nxt  = 1'b0;
    over_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    if (abort) begin
      // Abort wins over everything, including a coincident frame_start.
      state_nxt = ST_IDLE;
      wait_nxt  = '0;
      guard_nxt = '0;
      bin_nxt   = '0;
      acc_nxt   = '0;
    end else begin
      over_nxt = frame_start && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state_nxt = ST_REQ;
            bin_nxt   = '0;
          end
        end
        ST_REQ: begin
          state_nxt = ST_WAIT;
          wait_nxt  = '0;
        end
        ST_WAIT: begin
          // An ack on the final allowed cycle still counts as in time.
          if (calc_ack) begin
            state_nxt = ST_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt = ST_IDLE;
            tmo_nxt   = 1'b1;
          end else begin
            wait_nxt = 16'(wait_cnt + 16'd1);
          end
        end
        ST_DONE: begin
          if (calc_bin != LAST_BIN) begin
            bin_nxt   = 5'(calc_bin + 5'd1);
            state_nxt = ST_REQ;
          end else begin
            acc_nxt = acc_inc;
            if (acc_inc >= ACC_LIMIT) begin
              state_nxt = ST_GUARD;
              guard_nxt = '0;
            end else begin
              state_nxt = ST_IDLE;
              bin_nxt   = '0;
            end
          end
        end
        ST_GUARD: begin
          // Hold off the clear until the receiver's delayed cal_done landed.
          if (guard_cnt == GUARD_LAST) begin
            state_nxt = ST_ACC;
          end else begin
            guard_nxt = 16'(guard_cnt + 16'd1);
          end
        end
        ST_ACC: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
      req_nxt  = (state_nxt == ST_REQ);
      done_nxt = (state_nxt == ST_DONE);
      spec_nxt = (state_nxt == ST_ACC);
      if (state_nxt == ST_ACC) begin
        acc_nxt = '0;
        bin_nxt = '0;
      end
    end
    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_rangebin_sequencer.sv
// Scoreboard bench for rangebin_sequencer (N_BINS=4, ACC_NUM=2, TIMEOUT=8,
// GUARD=4): stimulus pushes expected pulse events, a monitor pops and compares.
module tb_rangebin_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       abort = 1'b0;
  logic       calc_ack = 1'b0;
  logic       calc_req;
  logic [4:0] calc_bin;
  logic       cal_done;
  logic       SPEC_Acc_Done;
  logic       busy;
  logic [7:0] acc_count;
  logic       overrun;
  logic       timeout_err;

  int n_cmp = 0;
  int n_fail = 0;

  // Expected events: bin index for cal_done/timeout, gap for SPEC, 1 for overrun.
  int q_done[$];
  int q_spec[$];
  int q_tmo[$];
  int q_ovr[$];

  bit skip_en = 1'b0;
  int skip_bin = 0;
  int stray_req = 0;
  int stray_seen = 0;
  int ack_cd = 0;

  int cyc = 0;
  int last_done_cyc = 0;
  int last_req_cyc = 0;

  logic [2:0] dly;
  int         rb_cnt;

  rangebin_sequencer #(
    .N_BINS(4), .ACC_NUM(2), .TIMEOUT(8), .GUARD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
    .calc_ack(calc_ack), .calc_req(calc_req), .calc_bin(calc_bin),
    .cal_done(cal_done), .SPEC_Acc_Done(SPEC_Acc_Done), .busy(busy),
    .acc_count(acc_count), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Receiver's range-bin counter: cal_done delayed 3 cycles, cleared by SPEC.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly    <= '0;
      rb_cnt <= 0;
    end else begin
      dly <= {dly[1:0], cal_done};
      if (SPEC_Acc_Done) rb_cnt <= 0;
      else if (dly[2]) rb_cnt <= rb_cnt + 1;
    end
  end

  // Calc engine: ack 3 cycles after each calc_req, optionally skipping a bin.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      calc_ack = 1'b0;
      if (ack_cd > 0) begin
        ack_cd--;
        if (ack_cd == 0) calc_ack = 1'b1;
      end
      if (calc_req && !(skip_en && int'(calc_bin) == skip_bin)) ack_cd = 3;
      if (stray_req != stray_seen) begin
        calc_ack   = 1'b1;
        stray_seen = stray_req;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a pulse.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (calc_req) last_req_cyc = cyc;
      if (cal_done || SPEC_Acc_Done)
        check("done_spec_exclusive", int'(cal_done & SPEC_Acc_Done), 0);
      if (cal_done) begin
        check("cal_done_expected", int'(q_done.size() > 0), 1);
        if (q_done.size() > 0) check("cal_done_bin", int'(calc_bin), q_done.pop_front());
        last_done_cyc = cyc;
      end
      if (SPEC_Acc_Done) begin
        check("spec_expected", int'(q_spec.size() > 0), 1);
        if (q_spec.size() > 0) begin
          check("spec_gap", cyc - last_done_cyc, q_spec.pop_front());
          check("rb_count_before_clear", rb_cnt, 8);
          check("spec_acc_count", int'(acc_count), 0);
        end
      end
      if (timeout_err) begin
        check("timeout_expected", int'(q_tmo.size() > 0), 1);
        if (q_tmo.size() > 0) begin
          check("timeout_bin", int'(calc_bin), q_tmo.pop_front());
          check("timeout_gap_8_9", int'((cyc - last_req_cyc) >= 8 && (cyc - last_req_cyc) <= 9), 1);
        end
      end
      if (overrun) begin
        check("overrun_expected", int'(q_ovr.size() > 0), 1);
        if (q_ovr.size() > 0) void'(q_ovr.pop_front());
      end
    end
  end

  task automatic pulse_fs();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic push_frame(input int nbins);
    for (int b = 0; b < nbins; b++) q_done.push_back(b);
  endtask

  task automatic wait_idle(input string name);
    int ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, int'({calc_req, cal_done, SPEC_Acc_Done, busy, overrun, timeout_err}), 0);
    check({name, "_bin"}, int'(calc_bin), 0);
    check({name, "_acc"}, int'(acc_count), 0);
  endtask

  initial begin
    int ok;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    // Single frame
    push_frame(4);
    pulse_fs();
    wait_idle("t1_idle");
    check("t1_acc", int'(acc_count), 1);
    check("t1_bin", int'(calc_bin), 0);

    // Second frame completes the accumulation
    push_frame(4);
    q_spec.push_back(5);
    pulse_fs();
    wait_idle("t2_idle");
    check("t2_acc", int'(acc_count), 0);
    check("t2_bin", int'(calc_bin), 0);

    // Timeout on bin 2
    skip_bin = 2;
    skip_en  = 1'b1;
    q_done.push_back(0);
    q_done.push_back(1);
    q_tmo.push_back(2);
    pulse_fs();
    wait_idle("t3_idle");
    check("t3_bin", int'(calc_bin), 2);
    check("t3_acc", int'(acc_count), 0);
    skip_en = 1'b0;

    // frame_start during WAIT: overrun, sweep unaffected
    push_frame(4);
    q_ovr.push_back(1);
    pulse_fs();
    pulse_fs();
    wait_idle("t4_idle");
    check("t4_acc", int'(acc_count), 1);

    // Stray ack in IDLE
    stray_req++;
    repeat (4) @(negedge clk);
    check("stray_busy", int'(busy), 0);
    check("stray_acc", int'(acc_count), 1);
    check("stray_bin", int'(calc_bin), 0);

    // abort together with frame_start in IDLE
    @(posedge clk);
    #1 begin abort = 1'b1; frame_start = 1'b1; end
    @(posedge clk);
    #1 begin abort = 1'b0; frame_start = 1'b0; end
    @(negedge clk);
    check("abort_fs_busy", int'(busy), 0);
    check("abort_fs_acc", int'(acc_count), 0);
    repeat (3) @(negedge clk);
    check("abort_fs_stays_idle", int'(busy), 0);

    // Abort during WAIT of bin 1 in frame 2
    push_frame(4);
    pulse_fs();
    wait_idle("t5a_idle");
    check("t5a_acc", int'(acc_count), 1);
    q_done.push_back(0);
    pulse_fs();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (calc_req && calc_bin == 5'd1) begin
        ok = 1;
        break;
      end
    end
    check("t5_req_bin1_seen", ok, 1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("t5_busy", int'(busy), 0);
    check("t5_bin", int'(calc_bin), 0);
    check("t5_acc", int'(acc_count), 0);
    repeat (8) @(negedge clk);
    check("t5_still_idle", int'(busy), 0);

    // Reset during GUARD
    push_frame(4);
    push_frame(4);
    pulse_fs();
    wait_idle("t6a_idle");
    pulse_fs();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_count == 8'd2) begin
        ok = 1;
        break;
      end
    end
    check("t6_guard_reached", ok, 1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_guard");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_after_busy", int'(busy), 0);
    check("t6_after_acc", int'(acc_count), 0);

    // Normal operation after reset release
    push_frame(4);
    pulse_fs();
    wait_idle("t7_idle");
    check("t7_acc", int'(acc_count), 1);

    repeat (2) @(negedge clk);
    check("left_done", q_done.size(), 0);
    check("left_spec", q_spec.size(), 0);
    check("left_tmo", q_tmo.size(), 0);
    check("left_ovr", q_ovr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/rangebin_sequencer.md
RANGEBIN_SEQUENCER -- requirements
Module: rangebin_sequencer

Interface
REQ-001 The block SHALL have parameter N_BINS, default 32, giving the number of range bins per frame (2..32).
REQ-002 The block SHALL have parameter ACC_NUM, default 16, giving the number of frames per spectrum accumulation (1..255).
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, giving the maximum number of cycles to wait for calc_ack (1..65535).
REQ-004 The block SHALL have parameter GUARD, default 4, giving the number of cycles from the last cal_done to SPEC_Acc_Done (>=4).
REQ-005 clk  input  1  single clock; all logic runs on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 frame_start  input  1  single-cycle request to sweep all bins of one frame.
REQ-008 abort  input  1  synchronous cancel of any activity.
REQ-009 calc_ack  input  1  single-cycle pulse from the calc engine: current bin finished.
REQ-010 calc_req  output  1  single-cycle pulse: start calculation of bin calc_bin.
REQ-011 calc_bin  output  5  index of the bin in progress.
REQ-012 cal_done  output  1  single-cycle pulse per completed bin, for the range-bin counter.
REQ-013 SPEC_Acc_Done  output  1  single-cycle pulse at end of accumulation; clears the range-bin counter.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 acc_count  output  8  frames completed in the current accumulation.
REQ-016 overrun  output  1  single-cycle pulse when frame_start is ignored.
REQ-017 timeout_err  output  1  single-cycle pulse when calc_ack does not arrive in time.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT, DONE, GUARD and ACC, with exactly one active state.
REQ-019 IDLE SHALL go to REQ on the cycle after frame_start=1, with calc_bin=0.
REQ-020 REQ SHALL assert calc_req for exactly one cycle and go to WAIT; calc_bin SHALL stay constant from REQ until DONE.
REQ-021 WAIT SHALL go to DONE on the cycle after calc_ack=1.
REQ-022 A calc_ack outside WAIT, including one that coincides with calc_req, SHALL be ignored.
REQ-023 A 16-bit wait counter SHALL clear on entry to WAIT.
REQ-024 If calc_ack has not arrived within TIMEOUT cycles, the block SHALL pulse timeout_err, issue no cal_done, go to IDLE, and keep calc_bin and acc_count unchanged.
REQ-025 DONE SHALL assert cal_done for exactly one cycle.
REQ-026 From DONE, if calc_bin<N_BINS-1, the block SHALL increment calc_bin and go to REQ.
REQ-027 From DONE on the last bin, the block SHALL increment acc_count.
REQ-028 From DONE on the last bin, if the new acc_count is below ACC_NUM, the block SHALL go to IDLE with calc_bin=0.
REQ-029 From DONE on the last bin, if the new acc_count equals ACC_NUM, the block SHALL go to GUARD.
REQ-030 GUARD SHALL count GUARD cycles and then go to ACC, so the receiver's 3-cycle delayed cal_done is counted before the clear.
REQ-031 ACC SHALL assert SPEC_Acc_Done for exactly one cycle, set acc_count=0 and calc_bin=0, and go to IDLE.
REQ-032 frame_start while busy=1 SHALL be ignored and SHALL pulse overrun on the next cycle.
REQ-033 abort SHALL take priority over every transition and, on the next cycle, give state=IDLE, calc_bin=0, acc_count=0, with no pulse output asserted.
REQ-034 abort and frame_start together in IDLE SHALL resolve to abort, with no overrun pulse.
REQ-035 cal_done and SPEC_Acc_Done SHALL never be high in the same cycle.
REQ-036 The minimum spacing from cal_done to SPEC_Acc_Done SHALL be GUARD+1 cycles.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 While rst_n=0, the block SHALL hold state=IDLE and every output at 0, regardless of clk.
REQ-039 The internal counters SHALL be 0 while rst_n=0.
REQ-040 An assertion of rst_n mid-frame SHALL discard all progress with no trailing pulse.
REQ-041 After rst_n deasserts, the block SHALL respond to frame_start no earlier than the first rising edge at which rst_n=1.

Verification (N_BINS=4, ACC_NUM=2, TIMEOUT=8, GUARD=4)
REQ-042 Single frame: frame_start, calc_ack 3 cycles after each calc_req -> calc_bin 0,1,2,3; four cal_done pulses; acc_count=1; no SPEC_Acc_Done; busy low afterwards.
REQ-043 Full accumulation: two frames -> eight cal_done pulses; SPEC_Acc_Done exactly 5 cycles after the eighth cal_done; acc_count returns to 0; a model counter driven through a 3-cycle delay reads 8 just before the clear.
REQ-044 Timeout: no calc_ack after calc_req for bin 2 -> timeout_err 8-9 cycles later; no third cal_done; calc_bin=2, busy=0.
REQ-045 Overrun, ignored ack and simultaneous events: frame_start during WAIT -> overrun pulse and sweep unaffected; calc_ack in IDLE -> no effect; abort together with frame_start in IDLE -> no overrun pulse and block stays idle.
REQ-046 Abort and reset mid-operation: abort during WAIT of bin 1 in frame 2 -> IDLE with calc_bin=0, acc_count=0, no SPEC_Acc_Done; rst_n low during GUARD -> outputs 0 at once and no SPEC_Acc_Done after release.
